mips32_mem_arbiter: RTL and testbench

Single-clock arbiter that shares one single-port, synchronous-read instruction/data memory between the MIPS32 fetch stage (read-only) and the memory stage (load/store). It sits between the pipeline stages and the 32-word memory array. It grants at most one access per cycle, with data-port priority and a starvation guard for fetch. It returns read data one cycle after grant, tagged to the owning requester.

---
 rtl/mips32_pkg.sv | 43 ++++
 rtl/mips32_starve_ctr.sv | 55 +++++
 rtl/mips32_mem_arbiter.sv | 97 +++++++++
 tb/tb_mips32_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes, memory requester ids
// and the arbiter priority-state encoding.
package mips32_pkg;

    // Opcodes of the teaching-subset MIPS32 core
    localparam logic [5:0] ADD  = 6'd0;
    localparam logic [5:0] SUB  = 6'd1;
    localparam logic [5:0] AND  = 6'd2;
    localparam logic [5:0] OR   = 6'd3;
    localparam logic [5:0] XOR  = 6'd4;
    localparam logic [5:0] SLT  = 6'd5;
    localparam logic [5:0] ADDI = 6'd6;
    localparam logic [5:0] LW   = 6'd7;
    localparam logic [5:0] SW   = 6'd8;
    localparam logic [5:0] BEQZ = 6'd9;

    // Instruction classes used by the decoder
    localparam logic [2:0] RR_ALU  = 3'd0;
    localparam logic [2:0] RM_ALU  = 3'd1;
    localparam logic [2:0] LOAD    = 3'd2;
    localparam logic [2:0] STORE   = 3'd3;
    localparam logic [2:0] BRANCH  = 3'd4;
    localparam logic [2:0] HALT    = 3'd5;

    // Requesters sharing the single memory port
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    // Which requester wins a simultaneous request
    localparam logic PRI_DATA  = 1'b0;
    localparam logic PRI_FETCH = 1'b1;

    typedef enum logic {
        DATA_PRI  = PRI_DATA,
        FETCH_PRI = PRI_FETCH
    } pri_state_t;

    // Increment that sticks at the given limit
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/mips32_starve_ctr.sv
// Fetch starvation guard: counts consecutive denied fetch cycles and hands
// conflict priority to fetch once the count reaches MAX_WAIT, returning it to
// the data port as soon as fetch has been served.
module mips32_starve_ctr
    import mips32_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic if_req,
    input  logic if_gnt,
    output logic fetch_pri
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    pri_state_t state;
    pri_state_t state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_nxt;

    // Priority state and wait counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DATA_PRI;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state logic; a held pipeline freezes both counter and priority
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        if (!hold) begin
            if (!if_req || if_gnt) begin
                wait_nxt = '0;
            end else begin
                wait_nxt = sat_inc(wait_cnt, WAIT_LIM);
            end
            case (state)
                DATA_PRI:  if (wait_nxt == WAIT_LIM) state_nxt = FETCH_PRI;
                FETCH_PRI: if (if_gnt) state_nxt = DATA_PRI;
                default:   state_nxt = DATA_PRI;
            endcase
        end
    end

    assign fetch_pri = (state == FETCH_PRI);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one single-port synchronous-read memory between instruction fetch and
// the data memory stage: one grant per cycle, data port preferred, fetch
// protected from starvation, read data returned one cycle after the grant.
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic fetch_pri;
    logic winner;
    logic rd_if;
    logic rd_dm;

    mips32_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .if_req    (if_req),
        .if_gnt    (if_gnt),
        .fetch_pri (fetch_pri)
    );

    assign winner = fetch_pri ? REQ_IF : REQ_DM;

    // Grant decision: nothing during reset or hold, a lone requester always wins
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst && !hold) begin
            if (if_req && dm_req) begin
                if_gnt = (winner == REQ_IF);
                dm_gnt = (winner == REQ_DM);
            end else begin
                if_gnt = if_req;
                dm_gnt = dm_req;
            end
        end
    end

    // Memory port mux driven by whichever requester holds the grant
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = dm_gnt & dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (dm_gnt) begin
            mem_addr = dm_addr;
            if (dm_we) mem_wdata = dm_wdata;
        end
    end

    // Remember who owns the read data arriving next cycle; stores need no return
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_if <= 1'b0;
            rd_dm <= 1'b0;
        end else begin
            rd_if <= if_gnt;
            rd_dm <= dm_gnt & ~dm_we;
        end
    end

    // A reset arriving while a read is in flight drops that read's data
    assign if_rvalid = rd_if & ~rst;
    assign dm_rvalid = rd_dm & ~rst;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: hand-computed vector table,
// a back-to-back fetch sequence, then randomized traffic against a reference model.
module tb_mips32_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam logic [31:0] LD = 32'h1111_1111;

    typedef struct {
        logic          rst;
        logic          hold;
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          dm_req;
        logic          dm_we;
        logic [AW-1:0] dm_addr;
        logic [DW-1:0] dm_wdata;
    } stim_t;

    typedef struct {
        logic          if_gnt;
        logic          dm_gnt;
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic          if_rvalid;
        logic [DW-1:0] if_rdata;
        logic          dm_rvalid;
        logic [DW-1:0] dm_rdata;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, hold, if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [32];
    int            streak;
    bit            fetch_first;
    bit            pend_if, pend_dm;
    logic [DW-1:0] pend_if_data, pend_dm_data;

    mips32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 5) ? 32'h1234_5678 : (32'hA000_0000 | 32'(a));
    endfunction

    // Memory array behind the arbiter: synchronous read, write at strobe
    logic [DW-1:0] mem [32];
    logic [31:0]   written = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? mem[mem_addr] : init_word(int'(mem_addr));
            end
        end
    end

    function automatic vec_t mk(input int r, input int h, input int ir, input int ia,
                                input int dr, input int dw, input int da, input logic [31:0] wd,
                                input int eig, input int edg, input int emw, input int ema,
                                input logic [31:0] emd, input int eiv, input logic [31:0] eid,
                                input int edv, input logic [31:0] edd);
        vec_t v;
        v.s.rst = 1'(r);        v.s.hold = 1'(h);
        v.s.if_req = 1'(ir);    v.s.if_addr = 5'(ia);
        v.s.dm_req = 1'(dr);    v.s.dm_we = 1'(dw);
        v.s.dm_addr = 5'(da);   v.s.dm_wdata = wd;
        v.e.if_gnt = 1'(eig);   v.e.dm_gnt = 1'(edg);
        v.e.mem_we = 1'(emw);   v.e.mem_addr = 5'(ema);
        v.e.mem_wdata = emd;
        v.e.if_rvalid = 1'(eiv); v.e.if_rdata = eid;
        v.e.dm_rvalid = 1'(edv); v.e.dm_rdata = edd;
        return v;
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst = s.rst;       hold = s.hold;
        if_req = s.if_req; if_addr = s.if_addr;
        dm_req = s.dm_req; dm_we = s.dm_we;
        dm_addr = s.dm_addr; dm_wdata = s.dm_wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL cycle %0d %s: got %h, expected %h", cyc, name, act, exp);
        end
    endtask

    task automatic checkAll(input exp_t e);
        checkOutput("if_gnt",    32'(if_gnt),    32'(e.if_gnt));
        checkOutput("dm_gnt",    32'(dm_gnt),    32'(e.dm_gnt));
        checkOutput("mem_en",    32'(mem_en),    32'(e.if_gnt | e.dm_gnt));
        checkOutput("mem_we",    32'(mem_we),    32'(e.mem_we));
        checkOutput("mem_addr",  32'(mem_addr),  32'(e.mem_addr));
        checkOutput("mem_wdata", mem_wdata,      e.mem_wdata);
        checkOutput("if_rvalid", 32'(if_rvalid), 32'(e.if_rvalid));
        checkOutput("if_rdata",  if_rdata,       e.if_rdata);
        checkOutput("dm_rvalid", 32'(dm_rvalid), 32'(e.dm_rvalid));
        checkOutput("dm_rdata",  dm_rdata,       e.dm_rdata);
    endtask

    // What the arbiter should show this cycle, from the current inputs and model state
    function automatic exp_t modelPredict();
        exp_t e;
        e.if_gnt = 1'b0;
        e.dm_gnt = 1'b0;
        if (!rst && !hold) begin
            if (if_req && dm_req) begin
                e.if_gnt = fetch_first;
                e.dm_gnt = !fetch_first;
            end else begin
                e.if_gnt = if_req;
                e.dm_gnt = dm_req;
            end
        end
        e.mem_we    = e.dm_gnt && dm_we;
        e.mem_addr  = e.if_gnt ? if_addr : (e.dm_gnt ? dm_addr : '0);
        e.mem_wdata = e.mem_we ? dm_wdata : '0;
        e.if_rvalid = !rst && pend_if;
        e.if_rdata  = e.if_rvalid ? pend_if_data : '0;
        e.dm_rvalid = !rst && pend_dm;
        e.dm_rdata  = e.dm_rvalid ? pend_dm_data : '0;
        return e;
    endfunction

    // Advance the model across the clock edge given this cycle's grants
    task automatic modelAdvance(input bit gi, input bit gd);
        if (rst) begin
            streak = 0;
            fetch_first = 0;
            pend_if = 0;
            pend_dm = 0;
        end else begin
            pend_if      = gi;
            pend_if_data = ref_mem[if_addr];
            pend_dm      = gd && !dm_we;
            pend_dm_data = ref_mem[dm_addr];
            if (gd && dm_we) ref_mem[dm_addr] = dm_wdata;
            if (!hold) begin
                if (gi) begin
                    streak = 0;
                    fetch_first = 0;
                end else if (!if_req) begin
                    streak = 0;
                end else begin
                    if (streak < MW) streak++;
                    if (streak == MW) fetch_first = 1;
                end
            end
        end
    endtask

    task automatic runCycle(input stim_t s, input exp_t te, input bit use_tbl,
                            output bit gi, output bit gd);
        exp_t me;
        @(negedge clk);
        applyStimulus(s);
        #1;
        me = modelPredict();
        checkAll(use_tbl ? te : me);
        gi = me.if_gnt;
        gd = me.dm_gnt;
        modelAdvance(me.if_gnt, me.dm_gnt);
        cyc++;
    endtask

    initial begin
        vec_t  tbl[$];
        stim_t s;
        exp_t  e;
        bit    gi, gd;
        bit    ir, dr, dw;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dd;

        applyStimulus('{1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0});
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        streak = 0; fetch_first = 0; pend_if = 0; pend_dm = 0;
        pend_if_data = '0; pend_dm_data = '0;

        // rst hold ir ia dr dw da wd | ifg dmg mwe maddr mwd | ifv ifd dmv dmd
        tbl.push_back(mk(1,0,1,0,1,0,1,LD, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,0,1,0,1,LD, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,0,1,0,1,LD, 0,1,0,1,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,5,0,0,0,0,  1,0,0,5,0, 0,0,1,32'hA000_0001));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0, 1,32'h1234_5678,0,0));
        tbl.push_back(mk(0,0,1,6,1,0,2,LD, 0,1,0,2,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,6,1,0,2,LD, 0,1,0,2,0, 0,0,1,32'hA000_0002));
        tbl.push_back(mk(0,0,1,6,1,0,2,LD, 0,1,0,2,0, 0,0,1,32'hA000_0002));
        tbl.push_back(mk(0,0,1,6,1,0,2,LD, 1,0,0,6,0, 0,0,1,32'hA000_0002));
        tbl.push_back(mk(0,0,1,6,1,0,2,LD, 0,1,0,2,0, 1,32'hA000_0006,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,7,32'hDEAD_BEEF, 0,1,1,7,32'hDEAD_BEEF, 0,0,1,32'hA000_0002));
        tbl.push_back(mk(0,0,1,7,0,0,0,0,  1,0,0,7,0, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0, 1,32'hDEAD_BEEF,0,0));
        tbl.push_back(mk(0,0,1,4,1,0,3,LD, 0,1,0,3,0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,4,1,0,3,LD, 0,0,0,0,0, 0,0,1,32'hA000_0003));
        tbl.push_back(mk(0,1,1,4,1,0,3,LD, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,4,1,0,3,LD, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,4,1,0,3,LD, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,4,1,0,3,LD, 0,1,0,3,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,4,1,0,3,LD, 0,1,0,3,0, 0,0,1,32'hA000_0003));
        tbl.push_back(mk(0,0,1,4,1,0,3,LD, 1,0,0,4,0, 0,0,1,32'hA000_0003));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0, 1,32'hA000_0004,0,0));
        tbl.push_back(mk(0,0,1,9,1,0,8,LD, 0,1,0,8,0, 0,0,0,0));
        tbl.push_back(mk(1,0,1,9,1,0,8,LD, 0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,9,1,0,10,LD, 0,1,0,10,0, 0,0,0,0));
        tbl.push_back(mk(0,0,1,9,1,0,10,LD, 0,1,0,10,0, 0,0,1,32'hA000_000A));
        tbl.push_back(mk(0,0,1,9,1,0,10,LD, 0,1,0,10,0, 0,0,1,32'hA000_000A));
        tbl.push_back(mk(0,0,1,9,1,0,10,LD, 1,0,0,9,0, 0,0,1,32'hA000_000A));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0, 1,32'hA000_0009,0,0));

        foreach (tbl[i]) runCycle(tbl[i].s, tbl[i].e, 1'b1, gi, gd);

        // Back-to-back fetches, one per cycle, each returning on the next cycle
        for (int i = 0; i <= 4; i++) begin
            s = '{1'b0, 1'b0, (i < 4), 5'(12 + i), 1'b0, 1'b0, '0, '0};
            e.if_gnt    = (i < 4);
            e.dm_gnt    = 1'b0;
            e.mem_we    = 1'b0;
            e.mem_addr  = (i < 4) ? 5'(12 + i) : '0;
            e.mem_wdata = '0;
            e.if_rvalid = (i > 0);
            e.if_rdata  = (i > 0) ? (32'hA000_0000 | 32'(11 + i)) : '0;
            e.dm_rvalid = 1'b0;
            e.dm_rdata  = '0;
            runCycle(s, e, 1'b1, gi, gd);
        end

        // Randomized traffic; requesters keep their request stable until granted
        ir = 0; dr = 0; dw = 0; ia = '0; da = '0; dd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!ir && $urandom_range(0, 1) == 1) begin
                ir = 1;
                ia = 5'($urandom_range(0, 31));
            end
            if (!dr && $urandom_range(0, 2) != 0) begin
                dr = 1;
                dw = ($urandom_range(0, 2) == 0);
                da = 5'($urandom_range(0, 31));
                dd = $urandom;
            end
            s.rst      = ($urandom_range(0, 59) == 0);
            s.hold     = ($urandom_range(0, 7) == 0);
            s.if_req   = ir;
            s.if_addr  = ia;
            s.dm_req   = dr;
            s.dm_we    = dw;
            s.dm_addr  = da;
            s.dm_wdata = dd;
            runCycle(s, e, 1'b0, gi, gd);
            if (s.rst || gi) ir = 0;
            if (s.rst || gd) dr = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
